imem_loader: RTL and testbench

Boot-time programmer that streams a program image into the instruction memory's write port. It accepts bytes over a valid/ready handshake and assembles them little-endian into 32-bit instructions. Each completed word is written to consecutive word-aligned addresses. The loader holds the CPU in reset/stall until the load completes, and it is the writer counterpart of the instruction memory's write interface.

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time programmer that streams a byte image into the
// instruction memory write port, packing bytes little-endian into 32-bit
// words at consecutive word-aligned addresses, and holds the CPU stalled
// until the image is complete.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             abort_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_inst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cpu_hold_o
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      inst_q, inst_d;
  logic             wr_en_q, wr_en_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;

  logic             byte_acc;
  logic             start_ok;
  logic [CNT_W-1:0] idx_inc;
  logic             idx_last;
  logic [31:0]      asm_ins;

  // Handshake, count-range and word-index helpers
  always_comb begin
    byte_acc = byte_valid_i & rdy_q & ~abort_i;
    start_ok = (word_count_i != '0) && (32'(word_count_i) <= DEPTH_L);
    idx_inc  = idx_q + CNT_W'(1);
    idx_last = (idx_inc == cnt_q);
  end

  // Assembly register with the incoming byte inserted at the current lane
  always_comb begin
    asm_ins = asm_q;
    unique case (lane_q)
      2'd0: asm_ins[7:0]   = byte_data_i;
      2'd1: asm_ins[15:8]  = byte_data_i;
      2'd2: asm_ins[23:16] = byte_data_i;
      2'd3: asm_ins[31:24] = byte_data_i;
      default: asm_ins = asm_q;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    hold_d  = hold_q;
    wr_en_d = 1'b0;
    rdy_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            cnt_d   = word_count_i;
            err_d   = 1'b0;
            hold_d  = 1'b1;
            idx_d   = '0;
            lane_d  = 2'd0;
            asm_d   = '0;
            state_d = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
          lane_d  = 2'd0;
          asm_d   = '0;
        end else if (byte_acc) begin
          asm_d  = asm_ins;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Present the completed word and its address during WRITE
            inst_d  = asm_ins;
            addr_d  = BASE_ADDR + (32'(idx_q) << 2);
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
          lane_d  = 2'd0;
          asm_d   = '0;
        end else begin
          idx_d   = idx_inc;
          asm_d   = '0;
          state_d = idx_last ? DONE : RECV;
        end
      end
      DONE: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Output flags follow the state being entered
    wr_en_d = (state_d == WRITE);
    rdy_d   = (state_d == RECV);
    busy_d  = (state_d == RECV) || (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      addr_q  <= BASE_ADDR;
      inst_q  <= '0;
      wr_en_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      wr_en_q <= wr_en_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // Abort wins in its own cycle: suppress the write and refuse the byte
  assign wr_en_o      = wr_en_q & ~abort_i;
  assign byte_ready_o = rdy_q & ~abort_i;
  assign wr_addr_o    = addr_q;
  assign wr_inst_o    = inst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_hold_o   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned CNT_W = 11;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] word_count_i;
  logic             abort_i;
  logic             byte_valid_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o;
  logic             wr_en_o;
  logic [31:0]      wr_addr_o;
  logic [31:0]      wr_inst_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             cpu_hold_o;

  int tests;
  int fails;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          done_cnt;
  int          rdy_viol;

  imem_loader #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .word_count_i(word_count_i),
    .abort_i     (abort_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_inst_o   (wr_inst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cpu_hold_o  (cpu_hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, done pulse count, and ready-vs-write exclusivity
  initial begin
    done_cnt = 0;
    rdy_viol = 0;
  end
  always @(posedge clk) begin
    if (wr_en_o) begin
      log_addr.push_back(wr_addr_o);
      log_data.push_back(wr_inst_o);
    end
    if (done_o) done_cnt++;
    if (busy_o && !abort_i && (wr_en_o == byte_ready_o)) rdy_viol++;
    if (wr_en_o && !busy_o) rdy_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] img_word(input int w);
    return 32'(w) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Offer one byte until a handshake completes; valid is left as-is afterwards
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    byte_data_i = b;
    while (!acc && n < 200) begin
      if (rnd) byte_valid_i = 1'($urandom_range(0, 1));
      else     byte_valid_i = 1'b1;
      acc = byte_valid_i && byte_ready_o;
      tick();
      n++;
    end
    if (!acc) check1("byte_accept", acc, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check1("done_seen", done_o, 1'b1);
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] cnt);
    start_i = 1'b1;
    word_count_i = cnt;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int lb;
    int db;
    logic [31:0] wv;
    logic [7:0]  bv;
    logic [7:0]  img8 [0:7];

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start_i = 1'b0;
    word_count_i = '0;
    abort_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = '0;

    // Reset values
    repeat (3) tick();
    check1("rst_ready", byte_ready_o, 1'b0);
    check1("rst_hold", cpu_hold_o, 1'b1);
    check("rst_addr", wr_addr_o, 32'h0);
    rst_n = 1'b1;
    tick();
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_wr_en", wr_en_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check("rst_inst", wr_inst_o, 32'h0);

    // Two-word load streamed back-to-back
    img8[0] = 8'h13; img8[1] = 8'h00; img8[2] = 8'h00; img8[3] = 8'h00;
    img8[4] = 8'h93; img8[5] = 8'h00; img8[6] = 8'h10; img8[7] = 8'h00;
    lb = log_addr.size();
    db = done_cnt;
    pulse_start(11'd2);
    check1("t1_busy", busy_o, 1'b1);
    check1("t1_ready", byte_ready_o, 1'b1);
    check1("t1_hold", cpu_hold_o, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(img8[i], 1'b0);
    check1("t1_wr_en0", wr_en_o, 1'b1);
    check1("t1_ready_wr", byte_ready_o, 1'b0);
    check("t1_addr0", wr_addr_o, 32'h0000_0000);
    check("t1_inst0", wr_inst_o, 32'h0000_0013);
    for (int i = 4; i < 8; i++) send_byte(img8[i], 1'b0);
    byte_valid_i = 1'b0;
    check1("t1_wr_en1", wr_en_o, 1'b1);
    check("t1_addr1", wr_addr_o, 32'h0000_0004);
    check("t1_inst1", wr_inst_o, 32'h0010_0093);
    tick();
    check1("t1_done", done_o, 1'b1);
    check1("t1_done_busy", busy_o, 1'b0);
    check1("t1_done_hold", cpu_hold_o, 1'b1);
    tick();
    check1("t1_done_off", done_o, 1'b0);
    check1("t1_hold_off", cpu_hold_o, 1'b0);
    check("t1_nwr", 32'(log_addr.size() - lb), 32'd2);
    check("t1_log_a1", log_addr[lb+1], 32'h0000_0004);
    check("t1_log_d0", log_data[lb], 32'h0000_0013);
    check("t1_ndone", 32'(done_cnt - db), 32'd1);

    // Same load with random valid gaps
    lb = log_addr.size();
    db = done_cnt;
    pulse_start(11'd2);
    for (int i = 0; i < 8; i++) send_byte(img8[i], 1'b1);
    byte_valid_i = 1'b0;
    wait_done();
    tick();
    check("t2_nwr", 32'(log_addr.size() - lb), 32'd2);
    check("t2_log_a0", log_addr[lb], 32'h0000_0000);
    check("t2_log_d0", log_data[lb], 32'h0000_0013);
    check("t2_log_a1", log_addr[lb+1], 32'h0000_0004);
    check("t2_log_d1", log_data[lb+1], 32'h0010_0093);
    check("t2_ndone", 32'(done_cnt - db), 32'd1);
    check("t2_rdy_viol", 32'(rdy_viol), 32'd0);
    check1("t2_hold", cpu_hold_o, 1'b0);

    // Out-of-range word counts
    lb = log_addr.size();
    pulse_start(11'd0);
    check1("t3_err0", err_o, 1'b1);
    check1("t3_busy0", busy_o, 1'b0);
    check1("t3_hold0", cpu_hold_o, 1'b0);
    tick();
    pulse_start(11'd1025);
    check1("t3_err1025", err_o, 1'b1);
    check1("t3_busy1025", busy_o, 1'b0);
    check1("t3_ready1025", byte_ready_o, 1'b0);
    repeat (4) tick();
    check("t3_nwr", 32'(log_addr.size() - lb), 32'd0);

    // Abort after six bytes of a three-word load
    lb = log_addr.size();
    db = done_cnt;
    pulse_start(11'd3);
    check1("t4_err_clr", err_o, 1'b0);
    check1("t4_hold", cpu_hold_o, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    byte_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check1("t4_err", err_o, 1'b1);
    check1("t4_hold_ab", cpu_hold_o, 1'b1);
    check1("t4_busy", busy_o, 1'b0);
    check1("t4_ready", byte_ready_o, 1'b0);
    repeat (2) tick();
    check("t4_nwr", 32'(log_addr.size() - lb), 32'd1);
    check("t4_log_a0", log_addr[lb], 32'h0000_0000);
    check("t4_log_d0", log_data[lb], 32'h4433_2211);
    check("t4_ndone", 32'(done_cnt - db), 32'd0);

    // Abort landing in the WRITE cycle suppresses that write
    pulse_start(11'd2);
    check1("t4b_err_clr", err_o, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    byte_valid_i = 1'b0;
    abort_i = 1'b1;
    #1;
    check1("t4b_wr_en_ab", wr_en_o, 1'b0);
    tick();
    abort_i = 1'b0;
    check1("t4b_err", err_o, 1'b1);
    check1("t4b_busy", busy_o, 1'b0);
    check1("t4b_hold", cpu_hold_o, 1'b1);
    tick();
    check("t4b_nwr", 32'(log_addr.size() - lb), 32'd1);

    // Full-depth load with stray start pulses mid-load
    lb = log_addr.size();
    db = done_cnt;
    pulse_start(11'd1024);
    check1("t5_err_clr", err_o, 1'b0);
    for (int w = 0; w < 1024; w++) begin
      wv = img_word(w);
      for (int l = 0; l < 4; l++) begin
        bv = wv[8*l +: 8];
        if ((w % 256) == 100 && l == 1) begin
          start_i = 1'b1;
          word_count_i = 11'd5;
        end
        send_byte(bv, 1'b0);
        start_i = 1'b0;
      end
    end
    byte_valid_i = 1'b0;
    wait_done();
    tick();
    check1("t5_hold_off", cpu_hold_o, 1'b0);
    check("t5_nwr", 32'(log_addr.size() - lb), 32'd1024);
    check("t5_ndone", 32'(done_cnt - db), 32'd1);
    if (log_addr.size() - lb == 1024) begin
      check("t5_last_addr", log_addr[lb+1023], 32'h0000_0FFC);
      for (int k = 0; k < 1024; k++) begin
        check("t5_addr", log_addr[lb+k], 32'(k) << 2);
        check("t5_data", log_data[lb+k], img_word(k));
      end
    end

    // Asynchronous reset in the middle of a word
    pulse_start(11'd2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    byte_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check1("t6_ready", byte_ready_o, 1'b0);
    check1("t6_busy", busy_o, 1'b0);
    check1("t6_hold", cpu_hold_o, 1'b1);
    check1("t6_wr_en", wr_en_o, 1'b0);
    check("t6_addr", wr_addr_o, 32'h0);
    check("t6_inst", wr_inst_o, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    lb = log_addr.size();
    pulse_start(11'd1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    byte_valid_i = 1'b0;
    check1("t6_wr_en1", wr_en_o, 1'b1);
    check("t6_addr1", wr_addr_o, 32'h0000_0000);
    check("t6_inst1", wr_inst_o, 32'hDEAD_BEEF);
    wait_done();
    tick();
    check1("t6_hold_off", cpu_hold_o, 1'b0);
    check("t6_nwr", 32'(log_addr.size() - lb), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
